// File: rtl/br_update_queue_if.sv
// Handshake and status bundle between the branch-resolution stage, the update queue and the predictor.
// The queue takes the slave modport; the environment driving it takes the master modport.
interface br_update_queue_if #(
    parameter int DEPTH  = 4,
    parameter int STAT_W = 32
);
    logic                     res_valid;
    logic [31:0]              res_pc;
    logic                     res_taken;
    logic                     res_pred;
    logic                     res_ready;
    logic                     upd_stall;
    logic                     upd_ld;
    logic                     upd_taken;
    logic [31:0]              upd_pc;
    logic                     mispredict;
    logic [31:0]              mispredict_pc;
    logic [$clog2(DEPTH):0]   count;
    logic [STAT_W-1:0]        stat_branches;
    logic [STAT_W-1:0]        stat_mispredicts;

    modport slave (
        input  res_valid, res_pc, res_taken, res_pred, upd_stall,
        output res_ready, upd_ld, upd_taken, upd_pc, mispredict, mispredict_pc,
               count, stat_branches, stat_mispredicts
    );

    modport master (
        output res_valid, res_pc, res_taken, res_pred, upd_stall,
        input  res_ready, upd_ld, upd_taken, upd_pc, mispredict, mispredict_pc,
               count, stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/br_update_queue.sv
// Resolved-branch update FIFO with registered mispredict flag and saturating stats; 1-cycle push-to-head, no bypass.
// res_ready drops only when full (a same-cycle pop grants no credit); upd_stall holds the head entry.
module br_update_queue #(
    parameter int DEPTH  = 4,
    parameter int STAT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    br_update_queue_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("br_update_queue: DEPTH must be a power of two >= 2");
    end

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             head;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               mispredict_q, mispredict_d;
    logic [31:0]        mis_pc_q, mis_pc_d;
    logic [STAT_W-1:0]  stat_br_q, stat_br_d;
    logic [STAT_W-1:0]  stat_mp_q, stat_mp_d;
    logic               empty, full, push, pop, mis_push;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign push     = bus.res_valid && !full && !rst;
    assign pop      = !rst && !empty && !bus.upd_stall;
    assign mis_push = push && (bus.res_taken != bus.res_pred);
    assign head     = mem_q[rd_ptr_q];

    // Reset forces the ready/strobe pair to its idle values even before the first edge clears state.
    assign bus.res_ready        = rst || !full;
    assign bus.upd_ld           = pop;
    assign bus.upd_pc           = empty ? 32'h0 : head.pc;
    assign bus.upd_taken        = empty ? 1'b0  : head.taken;
    assign bus.count            = count_q;
    assign bus.mispredict       = mispredict_q;
    assign bus.mispredict_pc    = mis_pc_q;
    assign bus.stat_branches    = stat_br_q;
    assign bus.stat_mispredicts = stat_mp_q;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        mispredict_d = mis_push;
        mis_pc_d     = mis_push ? bus.res_pc : mis_pc_q;
        stat_br_d    = stat_br_q;
        stat_mp_d    = stat_mp_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (push && stat_br_q != '1)     stat_br_d = stat_br_q + 1'b1;
        if (mis_push && stat_mp_q != '1) stat_mp_d = stat_mp_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            mispredict_q <= 1'b0;
            mis_pc_q     <= '0;
            stat_br_q    <= '0;
            stat_mp_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            mispredict_q <= mispredict_d;
            mis_pc_q     <= mis_pc_d;
            stat_br_q    <= stat_br_d;
            stat_mp_q    <= stat_mp_d;
        end
    end

    // Storage needs no reset: empty slots are never observable.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.res_pc, bus.res_taken};
    end
endmodule

// File: tb/tb_br_update_queue.sv
// Scoreboard bench for br_update_queue: inputs change 1 time unit after posedge, outputs are checked on negedge.
// A second instance with 4-bit statistics exercises counter saturation.
module tb_br_update_queue;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    br_update_queue_if #(.DEPTH(4), .STAT_W(32)) u_if ();
    br_update_queue_if #(.DEPTH(4), .STAT_W(4))  s_if ();

    br_update_queue #(.DEPTH(4), .STAT_W(32)) u_dut (.clk(clk), .rst(rst), .bus(u_if));
    br_update_queue #(.DEPTH(4), .STAT_W(4))  s_dut (.clk(clk), .rst(rst), .bus(s_if));

    typedef struct {
        logic [31:0] pc;
        logic        taken;
    } exp_t;

    exp_t        sb [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          m_cnt;
    logic        m_mis;
    logic [31:0] m_mis_pc;
    logic [31:0] m_br, m_mp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic tk, input logic pr);
        u_if.res_valid = v;
        u_if.res_pc    = pc;
        u_if.res_taken = tk;
        u_if.res_pred  = pr;
    endtask

    // One clock of the main instance: compare against the model, then advance the model past the edge.
    task automatic cycle();
        logic exp_ld, push, pop;
        @(negedge clk);
        if (rst) begin
            check("rst_upd_ld", u_if.upd_ld, 0);
            check("rst_res_ready", u_if.res_ready, 1);
        end else begin
            exp_ld = (m_cnt != 0) && !u_if.upd_stall;
            check("count", u_if.count, m_cnt);
            check("res_ready", u_if.res_ready, m_cnt != 4);
            check("upd_ld", u_if.upd_ld, exp_ld);
            if (m_cnt != 0) begin
                check("upd_pc", u_if.upd_pc, sb[0].pc);
                check("upd_taken", u_if.upd_taken, sb[0].taken);
            end else begin
                check("upd_pc_empty", u_if.upd_pc, 0);
                check("upd_taken_empty", u_if.upd_taken, 0);
            end
            check("mispredict", u_if.mispredict, m_mis);
            check("mispredict_pc", u_if.mispredict_pc, m_mis_pc);
            check("stat_branches", u_if.stat_branches, m_br);
            check("stat_mispredicts", u_if.stat_mispredicts, m_mp);
            push = u_if.res_valid && (m_cnt != 4);
            pop  = exp_ld;
            if (pop) void'(sb.pop_front());
            if (push) sb.push_back('{pc: u_if.res_pc, taken: u_if.res_taken});
            m_cnt = m_cnt + (push ? 1 : 0) - (pop ? 1 : 0);
            m_mis = push && (u_if.res_taken != u_if.res_pred);
            if (m_mis) m_mis_pc = u_if.res_pc;
            if (push && m_br != '1) m_br++;
            if (m_mis && m_mp != '1) m_mp++;
        end
        @(posedge clk);
        if (rst) begin
            sb.delete();
            m_cnt = 0; m_mis = 0; m_mis_pc = 0; m_br = 0; m_mp = 0;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0);
        u_if.upd_stall = 1'b0;
        s_if.res_valid = 1'b0; s_if.res_pc = 0; s_if.res_taken = 0; s_if.res_pred = 0;
        s_if.upd_stall = 1'b0;
        m_cnt = 0; m_mis = 0; m_mis_pc = 0; m_br = 0; m_mp = 0;
        cycle();
        apply_reset();
        cycle();

        // Scenario 1: single correctly predicted branch
        drive(1, 32'h100, 1, 1); cycle();
        drive(0, 0, 0, 0);       cycle();
        cycle();
        check("s1_count", u_if.count, 0);

        // Scenario 2: fill under stall, overflow push ignored, then drain
        apply_reset();
        u_if.upd_stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1, 32'h10 * i, i[0], 0); cycle();
        end
        drive(1, 32'h50, 1, 1); cycle();
        check("s2_full_count", u_if.count, 4);
        check("s2_full_ready", u_if.res_ready, 0);
        drive(0, 0, 0, 0);
        u_if.upd_stall = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        check("s2_stat_branches", u_if.stat_branches, 4);

        // Scenario 3: single mispredict
        apply_reset();
        drive(1, 32'h200, 0, 1); cycle();
        drive(0, 0, 0, 0);       cycle();
        check("s3_mispredict_pc", u_if.mispredict_pc, 32'h200);
        cycle();
        check("s3_mispredict_clear", u_if.mispredict, 0);
        cycle();

        // Scenario 4: steady push+pop at count 2, pointers wrap
        apply_reset();
        u_if.upd_stall = 1'b1;
        drive(1, 32'h300, 1, 0); cycle();
        drive(1, 32'h304, 0, 0); cycle();
        u_if.upd_stall = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h400 + 32'(4 * i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cycle();
        end
        check("s4_count", u_if.count, 2);
        drive(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle();

        // Scenario 5: reset with entries queued and a push in flight
        apply_reset();
        u_if.upd_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h500 + 32'(i), 1, 0); cycle();
        end
        drive(1, 32'h5FF, 0, 1);
        apply_reset();
        drive(0, 0, 0, 0);
        cycle();
        check("s5_count", u_if.count, 0);
        check("s5_stats", u_if.stat_branches, 0);
        u_if.upd_stall = 1'b0;

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            u_if.upd_stall = ($urandom_range(0, 2) == 0);
            cycle();
        end
        drive(0, 0, 0, 0);
        u_if.upd_stall = 1'b0;
        for (int i = 0; i < 6; i++) cycle();

        // Scenario 6: 4-bit statistics saturate at 15
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            s_if.res_valid = 1'b1;
            s_if.res_pc    = 32'h600 + 32'(i);
            s_if.res_taken = 1'b1;
            s_if.res_pred  = 1'b0;
            @(posedge clk); #1;
        end
        s_if.res_valid = 1'b0;
        @(negedge clk);
        check("s6_stat_branches", s_if.stat_branches, 15);
        check("s6_stat_mispredicts", s_if.stat_mispredicts, 15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/br_update_queue.md
BR_UPDATE_QUEUE -- requirements
Module: br_update_queue

Interface
REQ-001 Parameter DEPTH, default 4, entry count of the update FIFO; SHALL be a power of two, at least 2.
REQ-002 Parameter STAT_W, default 32, width of the statistics counters.
REQ-003 clk  in  1  clock; all state SHALL update on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 res_valid  in  1  execute stage presents a resolved conditional branch this cycle.
REQ-006 res_pc  in  32  PC of the resolved branch.
REQ-007 res_taken  in  1  actual branch outcome (1 = taken).
REQ-008 res_pred  in  1  direction predicted at fetch for this branch.
REQ-009 res_ready  out  1  queue can accept an entry this cycle.
REQ-010 upd_stall  in  1  predictor cannot take an update this cycle; head entry is held.
REQ-011 upd_ld  out  1  update strobe to predictor; drives glob_pred_ld.
REQ-012 upd_taken  out  1  outcome of head entry; drives cpu_br_en.
REQ-013 upd_pc  out  32  PC of head entry; drives write_pc.
REQ-014 mispredict  out  1  one-cycle pulse flagging a mispredicted accepted branch.
REQ-015 mispredict_pc  out  32  PC associated with the mispredict pulse.
REQ-016 count  out  $clog2(DEPTH)+1  number of valid entries.
REQ-017 stat_branches  out  STAT_W  accepted branch count.
REQ-018 stat_mispredicts  out  STAT_W  accepted mispredicted branch count.

Function
REQ-019 The queue SHALL accept an entry (push) in a cycle when res_valid=1 and res_ready=1; it SHALL store {res_pc, res_taken}.
REQ-020 res_ready SHALL equal (count != DEPTH), combinationally; a same-cycle pop SHALL NOT grant push credit when full.
REQ-021 res_valid while res_ready=0 SHALL be ignored: no entry, no statistics change, no mispredict.
REQ-022 upd_ld SHALL equal (count != 0) && !upd_stall, combinationally; upd_pc/upd_taken SHALL show the head entry whenever count != 0.
REQ-023 When count = 0, upd_pc SHALL be 0 and upd_taken SHALL be 0.
REQ-024 A pop SHALL occur in every cycle in which upd_ld=1; the head SHALL advance to the next-oldest entry.
REQ-025 There SHALL be no bypass: an entry pushed in cycle N SHALL appear on upd_* no earlier than cycle N+1.
REQ-026 Entries SHALL drain in strict acceptance order (FIFO).
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
REQ-028 Push and pop in the same cycle SHALL leave count unchanged, and both operations SHALL take effect.
REQ-029 count SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or go below 0.
REQ-030 mispredict SHALL be registered: it SHALL be 1 in cycle N+1 iff a push in cycle N had res_taken != res_pred.
REQ-031 mispredict_pc SHALL load res_pc of that push in the same cycle; otherwise mispredict_pc SHALL hold its value.
REQ-032 stat_branches SHALL increment by 1 per push; stat_mispredicts SHALL increment by 1 per mispredicted push.
REQ-033 Both statistics counters SHALL saturate at all-ones and not wrap.
REQ-034 upd_stall SHALL affect only the drain; accepts, mispredict and statistics SHALL proceed independently of it.

Reset
REQ-035 rst=1 at posedge SHALL clear both pointers, count, mispredict, mispredict_pc, stat_branches and stat_mispredicts to 0.
REQ-036 During and after rst, upd_ld=0 and res_ready=1.
REQ-037 rst SHALL take priority over a simultaneous push or pop; queued entries SHALL be discarded, including in-flight ones.

Verification
REQ-038 Scenario 1: push pc=0x100 taken=1 pred=1, upd_stall=0 -> next cycle upd_ld=1, upd_pc=0x100, upd_taken=1, mispredict=0; the following cycle count=0.
REQ-039 Scenario 2: upd_stall=1, push 0x10, 0x20, 0x30, 0x40 -> count=4, res_ready=0; a 5th push of 0x50 is ignored; release stall -> drains 0x10, 0x20, 0x30, 0x40 over 4 cycles, stat_branches=4.
REQ-040 Scenario 3: push pc=0x200 taken=0 pred=1 -> next cycle mispredict=1, mispredict_pc=0x200, stat_mispredicts=1; the cycle after, mispredict=0.
REQ-041 Scenario 4: count=2, simultaneous push and pop for 10 cycles (pointers wrap 2+ times) -> count stays 2; upd_pc sequence matches push order.
REQ-042 Scenario 5: count=3 with stall, assert rst with res_valid=1 -> next cycle count=0, upd_ld=0, stats=0, res_ready=1.
REQ-043 Scenario 6: STAT_W=4, 17 pushes, all mispredicted -> stat_branches=15, stat_mispredicts=15 (saturated).
